// File: rtl/serializer_slot_scheduler.sv
// Time-division scheduler: one requester word per SLOT_CYCLES-clock slot into a shared serializer.
// Latency: word taken at the slot boundary appears on PAR_IN 1 clock later and holds for a full slot.
// Backpressure: REQ_READY is a one-hot strobe in the boundary cycle only; requesters hold VALID until accepted.
module serializer_slot_scheduler #(
    parameter int                NUM_REQ     = 4,
    parameter int                WORD_W      = 16,
    parameter int                SLOT_CYCLES = 16,
    parameter int                MAX_BURST   = 2,
    parameter logic [WORD_W-1:0] IDLE_WORD   = '0
) (
    input  logic                         CLK,
    input  logic                         RESET,
    inout  wire                          VPWR,
    inout  wire                          VGND,
    input  logic [NUM_REQ-1:0]           REQ_VALID,
    input  logic [NUM_REQ*WORD_W-1:0]    REQ_DATA,
    input  logic [NUM_REQ-1:0]           REQ_ENABLE,
    output logic [NUM_REQ-1:0]           REQ_READY,
    output logic [WORD_W-1:0]            PAR_IN,
    output logic                         SLOT_START,
    output logic                         GRANT_VALID,
    output logic [$clog2(NUM_REQ)-1:0]   GRANT_ID
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(SLOT_CYCLES);
    localparam int BW  = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, OWN} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        slot_cnt;
    logic [BW-1:0]        burst_cnt, burst_d;
    logic [IDW-1:0]       rr_ptr, winner;
    logic                 win_vld;
    logic                 boundary;
    logic [NUM_REQ-1:0]   eligible;

    // Supply pins carry no logic in this model.
    wire unused_pwr_pins = VPWR ^ VGND;

    assign boundary = (slot_cnt == CW'(SLOT_CYCLES - 1));
    assign eligible = REQ_VALID & REQ_ENABLE;

    always_comb begin
        winner    = '0;
        win_vld   = 1'b0;
        burst_d   = '0;
        state_d   = state_q;
        REQ_READY = '0;
        if (boundary) begin
            if (state_q == OWN && eligible[GRANT_ID] && burst_cnt < BW'(MAX_BURST - 1)) begin
                winner  = GRANT_ID;
                win_vld = 1'b1;
                burst_d = burst_cnt + BW'(1);
            end else begin
                // Descending scan so the nearest index after rr_ptr is the last one written.
                for (int k = NUM_REQ; k >= 1; k--) begin
                    if (eligible[(int'(rr_ptr) + k) % NUM_REQ]) begin
                        winner  = IDW'((int'(rr_ptr) + k) % NUM_REQ);
                        win_vld = 1'b1;
                    end
                end
            end
            state_d = win_vld ? OWN : IDLE;
            if (win_vld) REQ_READY = NUM_REQ'(1) << winner;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            slot_cnt    <= '0;
            burst_cnt   <= '0;
            rr_ptr      <= IDW'(NUM_REQ - 1);
            PAR_IN      <= IDLE_WORD;
            SLOT_START  <= 1'b0;
            GRANT_VALID <= 1'b0;
            GRANT_ID    <= '0;
        end else begin
            slot_cnt   <= boundary ? '0 : slot_cnt + CW'(1);
            SLOT_START <= boundary;
            if (boundary) begin
                burst_cnt <= burst_d;
                if (win_vld) begin
                    PAR_IN      <= REQ_DATA[winner*WORD_W +: WORD_W];
                    GRANT_VALID <= 1'b1;
                    GRANT_ID    <= winner;
                    rr_ptr      <= winner;
                end else begin
                    PAR_IN      <= IDLE_WORD;
                    GRANT_VALID <= 1'b0;
                    GRANT_ID    <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_serializer_slot_scheduler.sv
module tb_serializer_slot_scheduler;
    logic        CLK;
    logic        RESET;
    wire         vpwr;
    wire         vgnd;
    logic [3:0]  REQ_VALID;
    logic [63:0] REQ_DATA;
    logic [3:0]  REQ_ENABLE;
    logic [3:0]  REQ_READY;
    logic [15:0] PAR_IN;
    logic        SLOT_START;
    logic        GRANT_VALID;
    logic [1:0]  GRANT_ID;

    assign vpwr = 1'b1;
    assign vgnd = 1'b0;

    serializer_slot_scheduler #(
        .NUM_REQ(4), .WORD_W(16), .SLOT_CYCLES(16), .MAX_BURST(2), .IDLE_WORD(16'h0000)
    ) dut (
        .CLK(CLK), .RESET(RESET), .VPWR(vpwr), .VGND(vgnd),
        .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_ENABLE(REQ_ENABLE),
        .REQ_READY(REQ_READY), .PAR_IN(PAR_IN), .SLOT_START(SLOT_START),
        .GRANT_VALID(GRANT_VALID), .GRANT_ID(GRANT_ID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        vld;
        logic [1:0]  id;
        logic [15:0] dat;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_par_in"},      32'(PAR_IN),      32'h0);
        check({tag, "_req_ready"},   32'(REQ_READY),   32'h0);
        check({tag, "_slot_start"},  32'(SLOT_START),  32'h0);
        check({tag, "_grant_valid"}, 32'(GRANT_VALID), 32'h0);
        check({tag, "_grant_id"},    32'(GRANT_ID),    32'h0);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        tick();
        tick();
        RESET = 1'b1;
        cyc = 0;
    endtask

    // Runs from the first cycle of a slot through its boundary and into the next slot.
    task automatic do_slot(input string tag, input logic [3:0] exp_ready, input int mid_at,
                           input logic [3:0] mid_valid, input logic [3:0] mid_enable,
                           input logic [63:0] mid_data);
        logic [3:0]  stray_rdy;
        logic        stray_ss;
        logic        moved;
        logic [18:0] snap;
        exp_t        e;
        stray_rdy = '0;
        stray_ss  = 1'b0;
        moved     = 1'b0;
        snap      = {GRANT_VALID, GRANT_ID, PAR_IN};
        do begin
            tick();
            if (cyc % 16 == mid_at) begin
                REQ_VALID  = mid_valid;
                REQ_ENABLE = mid_enable;
                REQ_DATA   = mid_data;
            end
            if (cyc % 16 != 15) begin
                stray_rdy |= REQ_READY;
                stray_ss  |= SLOT_START;
            end
            if ({GRANT_VALID, GRANT_ID, PAR_IN} !== snap) moved = 1'b1;
        end while (cyc % 16 != 15);
        check({tag, "_ready_outside_B"}, 32'(stray_rdy), 32'h0);
        check({tag, "_slot_start_mid"},  32'(stray_ss),  32'h0);
        check({tag, "_slot_stable"},     32'(moved),     32'h0);
        check({tag, "_ready_at_B"},      32'(REQ_READY), 32'(exp_ready));
        tick();
        check({tag, "_slot_start"}, 32'(SLOT_START), 32'h1);
        if (sb.size() == 0) begin
            check({tag, "_scoreboard_empty"}, 32'h1, 32'h0);
        end else begin
            e = sb.pop_front();
            check({tag, "_grant_valid"}, 32'(GRANT_VALID), 32'(e.vld));
            check({tag, "_grant_id"},    32'(GRANT_ID),    32'(e.id));
            check({tag, "_par_in"},      32'(PAR_IN),      32'(e.dat));
        end
    endtask

    initial begin
        RESET      = 1'b0;
        REQ_VALID  = '0;
        REQ_ENABLE = 4'b1111;
        REQ_DATA   = '0;
        cyc        = 0;
        tick();
        tick();
        check_reset_vals("reset");
        RESET = 1'b1;
        cyc   = 0;

        // Nothing valid: three idle slots
        for (int s = 0; s < 3; s++) begin
            sb.push_back('{1'b0, 2'd0, 16'h0000});
            do_slot("idle", 4'b0000, -1, REQ_VALID, REQ_ENABLE, REQ_DATA);
        end

        // Sole requester 1
        do_reset();
        REQ_VALID = 4'b0010;
        REQ_DATA  = {16'h0, 16'h0, 16'hC5AF, 16'h0};
        sb.push_back('{1'b1, 2'd1, 16'hC5AF});
        do_slot("req1", 4'b0010, -1, REQ_VALID, REQ_ENABLE, REQ_DATA);
        REQ_VALID = 4'b0000;
        sb.push_back('{1'b0, 2'd0, 16'h0000});
        do_slot("req1_hold", 4'b0000, -1, REQ_VALID, REQ_ENABLE, REQ_DATA);

        // All valid: bursts of two, rotating
        do_reset();
        REQ_VALID = 4'b1111;
        REQ_DATA  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
        begin
            int owners[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
            for (int s = 0; s < 9; s++) begin
                sb.push_back('{1'b1, 2'(owners[s]), 16'hA000 + 16'(owners[s])});
                do_slot("burst", 4'b0001 << owners[s], -1, REQ_VALID, REQ_ENABLE, REQ_DATA);
            end
        end

        // Masked requester 2, then enabled mid-slot
        REQ_VALID  = 4'b0100;
        REQ_ENABLE = 4'b1011;
        sb.push_back('{1'b0, 2'd0, 16'h0000});
        do_slot("masked", 4'b0000, -1, REQ_VALID, REQ_ENABLE, REQ_DATA);
        sb.push_back('{1'b1, 2'd2, 16'hA002});
        do_slot("unmask", 4'b0100, 5, 4'b0100, 4'b1111, REQ_DATA);

        // Owner drops VALID mid-slot, requester 3 takes the next slot
        REQ_VALID = 4'b0001;
        REQ_DATA  = {16'hF00F, 16'hA002, 16'hA001, 16'hFF00};
        sb.push_back('{1'b1, 2'd0, 16'hFF00});
        do_slot("own0", 4'b0001, -1, REQ_VALID, REQ_ENABLE, REQ_DATA);
        sb.push_back('{1'b1, 2'd3, 16'hF00F});
        do_slot("drop0", 4'b1000, 6, 4'b1000, 4'b1111,
                {16'hF00F, 16'hA002, 16'hA001, 16'h1234});

        // Reset mid-slot while a slot is owned
        for (int i = 0; i < 7; i++) tick();
        check("pre_reset_grant_valid", 32'(GRANT_VALID), 32'h1);
        RESET = 1'b0;
        #1;
        check_reset_vals("async_reset");
        tick();
        tick();
        RESET     = 1'b1;
        cyc       = 0;
        REQ_VALID = 4'b1111;
        sb.push_back('{1'b1, 2'd0, 16'h1234});
        do_slot("after_reset", 4'b0001, -1, REQ_VALID, REQ_ENABLE, REQ_DATA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
